// File: rtl/coproc_result_queue_pkg.sv
// Shared types for the coprocessor result queue: entry layout, result packet
// and the conversion from a head entry to what the result channel presents.
package coproc_result_queue_pkg;

  localparam int unsigned CP_ID_W   = 4;
  localparam int unsigned CP_XLEN   = 32;
  localparam int unsigned EXCCODE_W = 6;
  localparam int unsigned RD_W      = 5;

  typedef struct packed {
    logic valid;
    logic done;
    logic committed;
    logic killed;
  } entry_flags_t;

  typedef struct packed {
    entry_flags_t         flags;
    logic [CP_ID_W-1:0]   id;
    logic [RD_W-1:0]      rd;
    logic                 we;
    logic [CP_XLEN-1:0]   data;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
  } queue_entry_t;

  typedef struct packed {
    logic [CP_ID_W-1:0]   id;
    logic [CP_XLEN-1:0]   data;
    logic [RD_W-1:0]      rd;
    logic                 we;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
  } result_pkt_t;

  // A faulting instruction never writes its destination register.
  function automatic result_pkt_t entry_to_result(input queue_entry_t e);
    result_pkt_t p;
    p.id      = e.id;
    p.data    = e.data;
    p.rd      = e.rd;
    p.we      = e.we & ~e.exc;
    p.exc     = e.exc;
    p.exccode = e.exccode;
    return p;
  endfunction

endpackage

// File: rtl/coproc_result_queue_id_match.sv
// One-hot CAM lookup of an instruction ID against every valid queue entry.
module coproc_id_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][ID_W-1:0] ids,
  input  logic [ID_W-1:0]            key,
  output logic                       hit,
  output logic [DEPTH-1:0]           onehot
);

  // compare the key against each live entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = valid[i] & (ids[i] == key);
    end
  end

  assign hit = |onehot;

endmodule

// File: rtl/coproc_result_queue.sv
// In-order result/commit queue between coprocessor execute and the result
// channel; committed results leave in issue order, killed entries vanish.
module coproc_result_queue
  import coproc_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = CP_ID_W,
  parameter int unsigned XLEN       = CP_XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [X_ID_WIDTH-1:0]    alloc_id_i,
  input  logic [4:0]               alloc_rd_i,
  input  logic                     alloc_we_i,
  input  logic                     done_valid_i,
  input  logic [X_ID_WIDTH-1:0]    done_id_i,
  input  logic [XLEN-1:0]          done_data_i,
  input  logic                     done_exc_i,
  input  logic [5:0]               done_exccode_i,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic                     result_exc_o,
  output logic [5:0]               result_exccode_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     proto_err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  queue_entry_t                     entries_r [DEPTH];
  logic [PTR_W-1:0]                 head_r;
  logic [PTR_W-1:0]                 tail_r;
  logic [CNT_W-1:0]                 count_r;
  logic                             proto_err_r;

  logic [DEPTH-1:0]                 valid_s;
  logic [DEPTH-1:0][CP_ID_W-1:0]    ids_s;
  logic                             done_hit_s;
  logic [DEPTH-1:0]                 done_oh_s;
  logic                             commit_hit_s;
  logic [DEPTH-1:0]                 commit_oh_s;
  logic                             done_dup_s;
  logic                             commit_dup_s;
  logic                             proto_evt_s;
  logic                             alloc_s;
  logic                             head_kill_s;
  logic                             head_out_s;
  logic                             pop_s;
  queue_entry_t                     head_s;
  queue_entry_t                     alloc_entry_s;
  result_pkt_t                      result_pkt_s;

  // flatten entry state for the two ID lookups and flag repeat updates
  always_comb begin
    done_dup_s   = 1'b0;
    commit_dup_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i]   = entries_r[i].flags.valid;
      ids_s[i]     = entries_r[i].id;
      done_dup_s   = done_dup_s | (done_oh_s[i] & entries_r[i].flags.done);
      commit_dup_s = commit_dup_s | (commit_oh_s[i] &
                     (entries_r[i].flags.committed | entries_r[i].flags.killed));
    end
  end

  coproc_id_match #(.DEPTH(DEPTH), .ID_W(CP_ID_W)) u_done_match (
    .valid  (valid_s),
    .ids    (ids_s),
    .key    (done_id_i),
    .hit    (done_hit_s),
    .onehot (done_oh_s)
  );

  coproc_id_match #(.DEPTH(DEPTH), .ID_W(CP_ID_W)) u_commit_match (
    .valid  (valid_s),
    .ids    (ids_s),
    .key    (commit_id_i),
    .hit    (commit_hit_s),
    .onehot (commit_oh_s)
  );

  assign alloc_ready_o = (count_r < DEPTH_C);
  assign alloc_s       = alloc_valid_i & alloc_ready_o;
  assign head_s        = entries_r[head_r];
  assign head_kill_s   = head_s.flags.valid & head_s.flags.killed;
  assign head_out_s    = head_s.flags.valid & head_s.flags.done &
                         head_s.flags.committed & ~head_s.flags.killed;
  assign pop_s         = head_kill_s | (head_out_s & result_ready_i);
  assign proto_evt_s   = (done_valid_i & (~done_hit_s | done_dup_s)) |
                         (commit_valid_i & (~commit_hit_s | commit_dup_s));

  // fresh entry image written at the tail
  always_comb begin
    alloc_entry_s                 = '0;
    alloc_entry_s.flags.valid     = 1'b1;
    alloc_entry_s.id              = alloc_id_i;
    alloc_entry_s.rd              = alloc_rd_i;
    alloc_entry_s.we              = alloc_we_i;
  end

  // Outputs depend only on registered head state; zero when nothing is offered.
  always_comb begin
    if (head_out_s) begin
      result_pkt_s = entry_to_result(head_s);
    end else begin
      result_pkt_s = '0;
    end
  end

  assign result_valid_o   = head_out_s;
  assign result_id_o      = result_pkt_s.id;
  assign result_data_o    = result_pkt_s.data;
  assign result_rd_o      = result_pkt_s.rd;
  assign result_we_o      = result_pkt_s.we;
  assign result_exc_o     = result_pkt_s.exc;
  assign result_exccode_o = result_pkt_s.exccode;
  assign count_o          = count_r;
  assign proto_err_o      = proto_err_r;

  // Entry updates; a pop is written last so it overrides a same-cycle update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      proto_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (done_valid_i && done_oh_s[i] && !entries_r[i].flags.done) begin
          entries_r[i].flags.done <= 1'b1;
          entries_r[i].data       <= done_data_i;
          entries_r[i].exc        <= done_exc_i;
          entries_r[i].exccode    <= done_exccode_i;
        end
        if (commit_valid_i && commit_oh_s[i] &&
            !entries_r[i].flags.committed && !entries_r[i].flags.killed) begin
          entries_r[i].flags.committed <= ~commit_kill_i;
          entries_r[i].flags.killed    <= commit_kill_i;
        end
      end
      if (pop_s) begin
        entries_r[head_r].flags <= '0;
        head_r                  <= head_r + PTR_W'(1);
      end
      if (alloc_s) begin
        entries_r[tail_r] <= alloc_entry_s;
        tail_r            <= tail_r + PTR_W'(1);
      end
      if (proto_evt_s) begin
        proto_err_r <= 1'b1;
      end
      count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
    end
  end

endmodule

// File: tb/tb_coproc_result_queue.sv
// Scoreboard bench for coproc_result_queue: directed stimulus pushes expected
// results, an independent monitor pops and compares on each handshake.
module tb_coproc_result_queue;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alloc_valid_i = 1'b0;
  logic        alloc_ready_o;
  logic [3:0]  alloc_id_i = 4'h0;
  logic [4:0]  alloc_rd_i = 5'h0;
  logic        alloc_we_i = 1'b0;
  logic        done_valid_i = 1'b0;
  logic [3:0]  done_id_i = 4'h0;
  logic [31:0] done_data_i = 32'h0;
  logic        done_exc_i = 1'b0;
  logic [5:0]  done_exccode_i = 6'h0;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = 4'h0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        result_exc_o;
  logic [5:0]  result_exccode_o;
  logic [2:0]  count_o;
  logic        proto_err_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  coproc_result_queue #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_id_i(alloc_id_i), .alloc_rd_i(alloc_rd_i), .alloc_we_i(alloc_we_i),
    .done_valid_i(done_valid_i), .done_id_i(done_id_i), .done_data_i(done_data_i),
    .done_exc_i(done_exc_i), .done_exccode_i(done_exccode_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o),
    .count_o(count_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  // monitor: every accepted result must be the oldest expected one
  always @(negedge clk_i) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      exp_t act;
      act = '{id: result_id_o, data: result_data_o, rd: result_rd_o,
              we: result_we_o, exc: result_exc_o, exccode: result_exccode_o};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got id %0h data %h, expected no result", act.id, act.data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL result_pkt: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_alloc(input logic [3:0] id, input logic [4:0] rd, input logic we);
    alloc_valid_i = 1'b1; alloc_id_i = id; alloc_rd_i = rd; alloc_we_i = we;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic set_done(input logic [3:0] id, input logic [31:0] d,
                          input logic exc, input logic [5:0] code);
    done_valid_i = 1'b1; done_id_i = id; done_data_i = d;
    done_exc_i = exc; done_exccode_i = code;
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  task automatic clr_pulses();
    done_valid_i = 1'b0; commit_valid_i = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd,
                      input logic we, input logic exc, input logic [5:0] code);
    sb_q.push_back('{id: id, data: d, rd: rd, we: we & ~exc, exc: exc, exccode: code});
  endtask

  initial begin
    logic [3:0]  id_v;
    logic [31:0] d_v;
    logic [4:0]  rd_v;
    logic        we_v;
    logic        exc_v;
    logic [5:0]  code_v;

    // reset
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_count", count_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_result_data", result_data_o, 0);
    chk("rst_proto_err", proto_err_o, 0);

    // basic in-order
    do_alloc(4'd3, 5'd5, 1'b1);
    chk("basic_count1", count_o, 1);
    set_done(4'd3, 32'hDEADBEEF, 1'b0, 6'h0); tick(); clr_pulses();
    chk("basic_not_yet", result_valid_o, 0);
    set_commit(4'd3, 1'b0); push(4'd3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 6'h0);
    tick(); clr_pulses();
    chk("basic_valid", result_valid_o, 1);
    chk("basic_id", result_id_o, 3);
    chk("basic_rd", result_rd_o, 5);
    chk("basic_data", result_data_o, 64'hDEADBEEF);
    chk("basic_we", result_we_o, 1);
    tick();
    chk("basic_count0", count_o, 0);

    // out-of-order completion
    do_alloc(4'd1, 5'd1, 1'b1);
    do_alloc(4'd2, 5'd2, 1'b0);
    set_done(4'd2, 32'h2222_0002, 1'b0, 6'h0); tick(); clr_pulses();
    set_commit(4'd1, 1'b0); tick(); clr_pulses();
    set_commit(4'd2, 1'b0); tick(); clr_pulses();
    chk("ooo_hold", result_valid_o, 0);
    push(4'd1, 32'h1111_0001, 5'd1, 1'b1, 1'b0, 6'h0);
    push(4'd2, 32'h2222_0002, 5'd2, 1'b0, 1'b0, 6'h0);
    set_done(4'd1, 32'h1111_0001, 1'b0, 6'h0); tick(); clr_pulses();
    chk("ooo_first", result_id_o, 1);
    tick();
    chk("ooo_second", result_id_o, 2);
    tick();
    chk("ooo_count0", count_o, 0);

    // kill
    do_alloc(4'd4, 5'd4, 1'b1);
    do_alloc(4'd5, 5'd6, 1'b1);
    set_commit(4'd4, 1'b1); tick(); clr_pulses();
    chk("kill_no_valid", result_valid_o, 0);
    set_commit(4'd5, 1'b0); tick(); clr_pulses();
    chk("kill_freed", count_o, 1);
    push(4'd5, 32'h5555_AAAA, 5'd6, 1'b1, 1'b0, 6'h0);
    set_done(4'd5, 32'h5555_AAAA, 1'b0, 6'h0); tick(); clr_pulses();
    chk("kill_id5", result_id_o, 5);
    tick();
    chk("kill_count0", count_o, 0);

    // full / backpressure over three fill-drain rounds
    result_ready_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        id_v = 4'(r * 4 + i); rd_v = 5'(r * 4 + i + 1); we_v = (i % 2 == 0);
        do_alloc(id_v, rd_v, we_v);
      end
      chk("full_ready", alloc_ready_o, 0);
      chk("full_count", count_o, 4);
      do_alloc(4'hF, 5'd31, 1'b1);
      chk("full_reject", count_o, 4);
      for (int i = 0; i < 4; i++) begin
        id_v = 4'(r * 4 + i); rd_v = 5'(r * 4 + i + 1); we_v = (i % 2 == 0);
        d_v = 32'hA500_0000 + 32'(r * 256 + i);
        exc_v = (r == 2 && i == 2); code_v = exc_v ? 6'h0B : 6'h00;
        set_done(id_v, d_v, exc_v, code_v); set_commit(id_v, 1'b0);
        push(id_v, d_v, rd_v, we_v, exc_v, code_v);
        tick(); clr_pulses();
      end
      for (int s = 0; s < 5; s++) begin
        chk("stall_valid", result_valid_o, 1);
        chk("stall_id", result_id_o, 64'(r * 4));
        chk("stall_data", result_data_o, 64'(32'hA500_0000 + 32'(r * 256)));
        tick();
      end
      result_ready_i = 1'b1;
      alloc_valid_i = 1'b1; alloc_id_i = 4'hF;
      tick();
      alloc_valid_i = 1'b0;
      chk("no_bypass", count_o, 3);
      tick(); tick(); tick();
      chk("drain_count", count_o, 0);
      result_ready_i = 1'b0;
    end
    result_ready_i = 1'b1;

    // protocol error
    set_done(4'd9, 32'h9999_9999, 1'b0, 6'h0); tick(); clr_pulses();
    chk("perr_set", proto_err_o, 1);
    chk("perr_count", count_o, 0);
    chk("perr_valid", result_valid_o, 0);
    tick(); tick(); tick();
    chk("perr_sticky", proto_err_o, 1);

    // reset mid-flight
    result_ready_i = 1'b0;
    do_alloc(4'd10, 5'd10, 1'b1);
    do_alloc(4'd11, 5'd11, 1'b1);
    do_alloc(4'd12, 5'd12, 1'b1);
    set_done(4'd10, 32'hBAD0_0010, 1'b0, 6'h0); set_commit(4'd10, 1'b0);
    tick(); clr_pulses();
    chk("pre_rst_count", count_o, 3);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", result_valid_o, 0);
    chk("mid_rst_perr", proto_err_o, 0);
    result_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", result_valid_o, 0);
    set_done(4'd11, 32'h0, 1'b0, 6'h0); tick(); clr_pulses();
    chk("old_id_gone", proto_err_o, 1);
    tick();

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
